// File: rtl/segment_real_mode_arbiter_pkg.sv
// Shared types and defaults for the real-mode segment translation arbiter.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package segment_real_mode_arbiter_pkg;

  // Segment register select encoding; 6 and 7 are not valid selects.
  typedef enum logic [2:0] {
    SEG_ES = 3'd0,
    SEG_CS = 3'd1,
    SEG_SS = 3'd2,
    SEG_DS = 3'd3,
    SEG_FS = 3'd4,
    SEG_GS = 3'd5
  } seg_sel_e;

  // Requester identity, also the index of its lane in the request bus.
  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  localparam int          NUM_SEGS          = 6;
  localparam logic [31:0] SEG_LIMIT_DEFAULT = 32'h0000_FFFF;
  localparam logic [15:0] RESET_CS_DEFAULT  = 16'hF000;

  // True for a select that names one of the six segment registers.
  function automatic logic seg_sel_ok(input logic [2:0] sel);
    return sel < 3'd6;
  endfunction

endpackage

// File: rtl/segment_real_mode_arbiter_if.sv
// Request/response bundle between the two requesters and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req_ready per requester lane, rsp_ready on the response.
// Ports: req_valid/req_ready [1:0], req_seg [5:0], req_offset [63:0],
//        seg_wr_en/sel/data, a20_enable, rsp_valid/ready/id/linear/fault.
interface segment_real_mode_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_seg;      // [2:0] fetch, [5:3] data
  logic [63:0] req_offset;   // [31:0] fetch, [63:32] data
  logic        seg_wr_en;
  logic [2:0]  seg_wr_sel;
  logic [15:0] seg_wr_data;
  logic        a20_enable;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_linear;
  logic        rsp_fault;

  // Requester / environment side.
  modport master (
    output req_valid, req_seg, req_offset, seg_wr_en, seg_wr_sel, seg_wr_data,
           a20_enable, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_linear, rsp_fault
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_seg, req_offset, seg_wr_en, seg_wr_sel, seg_wr_data,
           a20_enable, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_linear, rsp_fault
  );
endinterface

// File: rtl/seg_real_xlate.sv
// Real-mode address translation: (seg << 4) + offset with A20 masking and limit check.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: seg_sel, seg_val, offset, a20_enable -> linear, fault.
module seg_real_xlate
  import segment_real_mode_arbiter_pkg::*;
#(
  parameter logic [31:0] SEG_LIMIT = SEG_LIMIT_DEFAULT
) (
  input  logic [2:0]  seg_sel,
  input  logic [15:0] seg_val,
  input  logic [31:0] offset,
  input  logic        a20_enable,
  output logic [31:0] linear,
  output logic        fault
);

  logic        sel_ok;
  logic [31:0] sum;

  always_comb begin
    sel_ok = seg_sel_ok(seg_sel);
    // 32-bit add wraps naturally modulo 2^32.
    sum = ({16'h0, seg_val} << 4) + offset;
    if (!a20_enable) begin
      sum[20] = 1'b0;
    end
    // An over-limit offset still reports its address; a bad select reports 0.
    linear = sel_ok ? sum : 32'h0;
    fault  = !sel_ok || (offset > SEG_LIMIT);
  end

endmodule

// File: rtl/segment_real_mode_arbiter.sv
// Round-robin arbiter of fetch/data requesters onto one real-mode translator.
// Latency: 1 cycle from accept to rsp_valid, one response per cycle sustained.
// Backpressure: single output register; requests stall while rsp_valid && !rsp_ready.
// Ports: clk, reset_n, bus (slave modport of segment_real_mode_arbiter_if).
module segment_real_mode_arbiter
  import segment_real_mode_arbiter_pkg::*;
#(
  parameter logic [31:0] SEG_LIMIT = SEG_LIMIT_DEFAULT,
  parameter logic [15:0] RESET_CS  = RESET_CS_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  segment_real_mode_arbiter_if.slave   bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]  state;
  logic [15:0] seg_q [NUM_SEGS];
  req_id_e     last_gnt;
  req_id_e     rsp_id_q;
  logic [31:0] rsp_linear_q;
  logic        rsp_fault_q;

  logic        can_accept;
  logic        gnt_data;
  logic        gnt_fetch;
  logic        accept;
  req_id_e     gnt_id;
  logic [2:0]  gnt_sel;
  logic [31:0] gnt_offset;
  logic [15:0] seg_val;
  logic [31:0] xl_linear;
  logic        xl_fault;

  // The output register can take a new entry if it is empty or draining now.
  assign can_accept = (state == ST_EMPTY) || bus.rsp_ready;

  // Data wins when it is alone, or when both are valid and fetch went last.
  assign gnt_data  = bus.req_valid[1] && (!bus.req_valid[0] || (last_gnt == REQ_FETCH));
  assign gnt_fetch = bus.req_valid[0] && !gnt_data;

  assign bus.req_ready = can_accept ? {gnt_data, gnt_fetch} : 2'b00;
  assign accept        = |bus.req_ready;

  assign gnt_id     = gnt_data ? REQ_DATA : REQ_FETCH;
  assign gnt_sel    = gnt_data ? bus.req_seg[5:3]     : bus.req_seg[2:0];
  assign gnt_offset = gnt_data ? bus.req_offset[63:32] : bus.req_offset[31:0];

  // A load to the selected register in the same cycle is seen by the translation.
  always_comb begin
    seg_val = 16'h0;
    if (seg_sel_ok(gnt_sel)) begin
      if (bus.seg_wr_en && (bus.seg_wr_sel == gnt_sel)) begin
        seg_val = bus.seg_wr_data;
      end else begin
        seg_val = seg_q[gnt_sel];
      end
    end
  end

  seg_real_xlate #(
    .SEG_LIMIT (SEG_LIMIT)
  ) u_xlate (
    .seg_sel    (gnt_sel),
    .seg_val    (seg_val),
    .offset     (gnt_offset),
    .a20_enable (bus.a20_enable),
    .linear     (xl_linear),
    .fault      (xl_fault)
  );

  // Segment register file; loads with select 6/7 are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SEGS; i++) begin
        seg_q[i] <= 16'h0;
      end
      seg_q[SEG_CS] <= RESET_CS;
    end else if (bus.seg_wr_en && seg_sel_ok(bus.seg_wr_sel)) begin
      seg_q[bus.seg_wr_sel] <= bus.seg_wr_data;
    end
  end

  // Output stage, occupancy state and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_EMPTY;
      last_gnt     <= REQ_DATA;   // so fetch wins the first contested cycle
      rsp_id_q     <= REQ_FETCH;
      rsp_linear_q <= 32'h0;
      rsp_fault_q  <= 1'b0;
    end else begin
      if (accept) begin
        state        <= ST_FULL;
        last_gnt     <= gnt_id;
        rsp_id_q     <= gnt_id;
        rsp_linear_q <= xl_linear;
        rsp_fault_q  <= xl_fault;
      end else if (bus.rsp_ready) begin
        state <= ST_EMPTY;
      end
    end
  end

  assign bus.rsp_valid  = (state == ST_FULL);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_linear = rsp_linear_q;
  assign bus.rsp_fault  = rsp_fault_q;

endmodule

// File: tb/tb_segment_real_mode_arbiter.sv
// Self-checking bench for segment_real_mode_arbiter: directed table, corner
// sequences (alternation, stall, async reset) and a randomized run against a
// behavioural model.
module tb_segment_real_mode_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  segment_real_mode_arbiter_if bus ();

  segment_real_mode_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  v;
    logic [2:0]  s0;
    logic [2:0]  s1;
    logic [31:0] o0;
    logic [31:0] o1;
    logic        we;
    logic [2:0]  ws;
    logic [15:0] wd;
    logic        a20;
    logic        rr;
    logic [1:0]  exp_rdy;
    logic        exp_vld;
    logic        exp_id;
    logic [31:0] exp_lin;
    logic        exp_flt;
  } vec_t;

  vec_t tbl [8];

  // Behavioural model state.
  logic [15:0] m_seg [6];
  logic        m_pv;
  int          m_pid;
  logic [31:0] m_plin;
  logic        m_pflt;
  int          m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [2:0] s0, input logic [2:0] s1,
                       input logic [31:0] o0, input logic [31:0] o1, input logic we,
                       input logic [2:0] ws, input logic [15:0] wd, input logic a20,
                       input logic rr);
    bus.req_valid   = v;
    bus.req_seg     = {s1, s0};
    bus.req_offset  = {o1, o0};
    bus.seg_wr_en   = we;
    bus.seg_wr_sel  = ws;
    bus.seg_wr_data = wd;
    bus.a20_enable  = a20;
    bus.rsp_ready   = rr;
  endtask

  task automatic idle(input logic rr);
    drive(2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 16'h0, 1'b1, rr);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    idle(1'b1);
    reset_n = 1'b0;
    tick();
    tick();
    check("rst_vld", 32'(bus.rsp_valid), 32'h0);
    check("rst_id", 32'(bus.rsp_id), 32'h0);
    check("rst_lin", bus.rsp_linear, 32'h0);
    check("rst_flt", 32'(bus.rsp_fault), 32'h0);
    reset_n = 1'b1;
  endtask

  // Real-mode translation straight from its definition.
  function automatic logic [31:0] ref_lin(input logic [15:0] segv, input logic [31:0] off,
                                          input logic a20, input logic [2:0] sel);
    logic [31:0] r;
    if (sel >= 3'd6) return 32'h0;
    r = 32'(segv) * 32'd16 + off;
    if (!a20) r = r & 32'hFFEF_FFFF;
    return r;
  endfunction

  function automatic logic [2:0] rand_sel();
    if ($urandom_range(0, 7) == 0) return 3'($urandom_range(6, 7));
    return 3'($urandom_range(0, 5));
  endfunction

  function automatic logic [31:0] rand_off();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_FFF0 + 32'($urandom_range(0, 31));
      1:       return $urandom;
      default: return 32'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    //        v      s0    s1    o0            o1            we    ws    wd        a20   rr    rdy    vld   id    lin           flt
    tbl[0] = '{2'b01, 3'd1, 3'd0, 32'h0000FFF0, 32'h0,        1'b0, 3'd0, 16'h0,    1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 32'h000FFFF0, 1'b0};
    tbl[1] = '{2'b00, 3'd1, 3'd0, 32'h0,        32'h0,        1'b1, 3'd3, 16'hFFFF, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0,        1'b0};
    tbl[2] = '{2'b10, 3'd0, 3'd3, 32'h0,        32'h0000FFFF, 1'b0, 3'd0, 16'h0,    1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 32'h0010FFEF, 1'b0};
    tbl[3] = '{2'b10, 3'd0, 3'd3, 32'h0,        32'h0000FFFF, 1'b0, 3'd0, 16'h0,    1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 32'h0000FFEF, 1'b0};
    tbl[4] = '{2'b01, 3'd1, 3'd0, 32'h00010000, 32'h0,        1'b0, 3'd0, 16'h0,    1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 32'h00100000, 1'b1};
    tbl[5] = '{2'b10, 3'd0, 3'd7, 32'h0,        32'h00000010, 1'b0, 3'd0, 16'h0,    1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 32'h0,        1'b1};
    tbl[6] = '{2'b10, 3'd0, 3'd3, 32'h0,        32'h00000010, 1'b1, 3'd3, 16'h1234, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 32'h00012350, 1'b0};
    tbl[7] = '{2'b01, 3'd0, 3'd0, 32'h00000005, 32'h0,        1'b0, 3'd0, 16'h0,    1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 32'h00000005, 1'b0};

    idle(1'b1);
    #2;
    do_reset();

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].s0, tbl[i].s1, tbl[i].o0, tbl[i].o1, tbl[i].we,
            tbl[i].ws, tbl[i].wd, tbl[i].a20, tbl[i].rr);
      #1;
      check($sformatf("v%0d_rdy", i), 32'(bus.req_ready), 32'(tbl[i].exp_rdy));
      tick();
      check($sformatf("v%0d_vld", i), 32'(bus.rsp_valid), 32'(tbl[i].exp_vld));
      if (tbl[i].exp_vld) begin
        check($sformatf("v%0d_id", i), 32'(bus.rsp_id), 32'(tbl[i].exp_id));
        check($sformatf("v%0d_lin", i), bus.rsp_linear, tbl[i].exp_lin);
        check($sformatf("v%0d_flt", i), 32'(bus.rsp_fault), 32'(tbl[i].exp_flt));
      end
    end

    // Both requesters valid with rsp_ready high: fetch, data, fetch, data.
    do_reset();
    drive(2'b11, 3'd1, 3'd0, 32'h0, 32'h4, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("alt%0d_rdy", k), 32'(bus.req_ready), (k % 2 == 1) ? 32'h2 : 32'h1);
      tick();
      check($sformatf("alt%0d_vld", k), 32'(bus.rsp_valid), 32'h1);
      check($sformatf("alt%0d_id", k), 32'(bus.rsp_id), 32'(k % 2));
      check($sformatf("alt%0d_lin", k), bus.rsp_linear, (k % 2 == 1) ? 32'h4 : 32'h000F0000);
    end

    // Stall for 3 cycles, then drain, then reset while FULL.
    do_reset();
    drive(2'b01, 3'd1, 3'd0, 32'h100, 32'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1);
    tick();
    check("stall_pre_lin", bus.rsp_linear, 32'h000F0100);
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 3'd1, 3'd3, 32'h200, 32'h20, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
      #1;
      check($sformatf("stall%0d_rdy", k), 32'(bus.req_ready), 32'h0);
      tick();
      check($sformatf("stall%0d_vld", k), 32'(bus.rsp_valid), 32'h1);
      check($sformatf("stall%0d_id", k), 32'(bus.rsp_id), 32'h0);
      check($sformatf("stall%0d_lin", k), bus.rsp_linear, 32'h000F0100);
      check($sformatf("stall%0d_flt", k), 32'(bus.rsp_fault), 32'h0);
    end
    drive(2'b11, 3'd1, 3'd3, 32'h200, 32'h20, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1);
    #1;
    check("drain_rdy", 32'(bus.req_ready), 32'h2);
    tick();
    check("drain_id", 32'(bus.rsp_id), 32'h1);
    check("drain_lin", bus.rsp_linear, 32'h00000020);
    idle(1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_vld", 32'(bus.rsp_valid), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check("noreplay_vld", 32'(bus.rsp_valid), 32'h0);
    drive(2'b01, 3'd1, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1);
    #1;
    check("cs_rdy", 32'(bus.req_ready), 32'h1);
    tick();
    check("cs_lin", bus.rsp_linear, 32'h000F0000);

    // Randomized run against the behavioural model.
    do_reset();
    for (int i = 0; i < 6; i++) m_seg[i] = 16'h0;
    m_seg[1] = 16'hF000;
    m_pv = 1'b0; m_pid = 0; m_plin = 32'h0; m_pflt = 1'b0; m_last = 1;
    for (int n = 0; n < 400; n++) begin
      logic [1:0]  v, er;
      logic [2:0]  s0, s1, ws, sel;
      logic [31:0] o0, o1, off;
      logic        we, a20, rr;
      logic [15:0] wd, sv;
      int          win;
      v = 2'($urandom_range(0, 3));
      s0 = rand_sel(); s1 = rand_sel();
      o0 = rand_off(); o1 = rand_off();
      we = ($urandom_range(0, 3) == 0);
      ws = 3'($urandom_range(0, 7));
      wd = 16'($urandom);
      a20 = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 3) != 0);
      drive(v, s0, s1, o0, o1, we, ws, wd, a20, rr);
      win = -1;
      if (!m_pv || rr) begin
        if (v == 2'b11) win = (m_last == 1) ? 0 : 1;
        else if (v[0]) win = 0;
        else if (v[1]) win = 1;
      end
      er = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;
      #1;
      check($sformatf("rnd%0d_rdy", n), 32'(bus.req_ready), 32'(er));
      tick();
      if (win >= 0) begin
        sel = (win == 1) ? s1 : s0;
        off = (win == 1) ? o1 : o0;
        sv = 16'h0;
        if (sel < 3'd6) sv = (we && ws == sel) ? wd : m_seg[sel];
        m_pv = 1'b1;
        m_pid = win;
        m_plin = ref_lin(sv, off, a20, sel);
        m_pflt = (sel >= 3'd6) || (off > 32'h0000FFFF);
        m_last = win;
      end else if (rr) begin
        m_pv = 1'b0;
      end
      if (we && ws < 3'd6) m_seg[ws] = wd;
      check($sformatf("rnd%0d_vld", n), 32'(bus.rsp_valid), 32'(m_pv));
      if (m_pv) begin
        check($sformatf("rnd%0d_id", n), 32'(bus.rsp_id), 32'(m_pid));
        check($sformatf("rnd%0d_lin", n), bus.rsp_linear, m_plin);
        check($sformatf("rnd%0d_flt", n), 32'(bus.rsp_fault), 32'(m_pflt));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/segment_real_mode_arbiter.md
SEGMENT_REAL_MODE_ARBITER -- requirements
Module: segment_real_mode_arbiter

Interface
REQ-001 Parameter SEG_LIMIT, default 32'h0000_FFFF, real-mode offset limit; offsets above it fault.
REQ-002 Parameter RESET_CS, default 16'hF000, CS register value after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  2  translation request; bit0 = fetch requester, bit1 = data requester.
REQ-006 req_ready  output  2  per-requester grant; a request is accepted when req_valid[i] and req_ready[i] are both high.
REQ-007 req_seg  input  6  3-bit segment select per requester ([2:0] fetch, [5:3] data); 0 ES, 1 CS, 2 SS, 3 DS, 4 FS, 5 GS; 6 and 7 invalid.
REQ-008 req_offset  input  64  32-bit offset per requester ([31:0] fetch, [63:32] data).
REQ-009 seg_wr_en / seg_wr_sel / seg_wr_data  input  1/3/16  segment register load port.
REQ-010 a20_enable  input  1  when low, bit 20 of every linear address is forced to 0.
REQ-011 rsp_valid / rsp_ready  output/input  1/1  response handshake.
REQ-012 rsp_id  output  1  requester of the current response (0 fetch, 1 data).
REQ-013 rsp_linear  output  32  translated linear address.
REQ-014 rsp_fault  output  1  limit violation or invalid segment select.

Function
REQ-015 The block holds six 16-bit segment registers; writes with seg_wr_sel 6 or 7 are ignored.
REQ-016 linear = ({16'h0, seg} << 4) + offset, computed modulo 2^32, then bit 20 is cleared when a20_enable is 0.
REQ-017 rsp_fault = (offset > SEG_LIMIT) or (seg select >= 6); rsp_linear is still driven when rsp_fault is set, except that it is 0 for an invalid select.
REQ-018 The output stage is a single register: the block accepts a request only when rsp_valid is low, or when rsp_valid and rsp_ready are both high in the same cycle.
REQ-019 Latency: a request accepted in cycle N presents rsp_valid in cycle N+1.
REQ-020 At most one req_ready bit is high per cycle; req_ready is 0 for a requester whose req_valid is low.
REQ-021 Arbitration is round-robin: when both requesters are valid, the one not granted last wins; a lone valid requester always wins; the pointer updates only on accept.
REQ-022 A same-cycle seg_wr_en targeting the select of the granted request is forwarded: the translation uses seg_wr_data.
REQ-023 While rsp_valid and !rsp_ready, rsp_id, rsp_linear and rsp_fault hold stable and req_ready is 0.
REQ-024 FSM states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-025 FSM transitions: EMPTY->FULL on accept; FULL->EMPTY on rsp_ready with no accept; FULL->FULL on rsp_ready with accept, or on !rsp_ready.

Reset
REQ-026 On reset_n low, asynchronously: CS = RESET_CS, other segment registers 0, state EMPTY, rsp_valid 0, rsp_id 0, rsp_linear 0, rsp_fault 0, round-robin pointer set so fetch wins first.
REQ-027 Reset asserted mid-operation discards any pending response; no response is replayed after release.

Structure
REQ-028 A shared package holds the segment select enum (ES..GS), the requester ID enum, and the SEG_LIMIT/RESET_CS defaults.
REQ-029 The address arithmetic is one combinational sub-module, seg_real_xlate (seg, offset, a20_enable -> linear, fault), instantiated once after the grant mux.

Verification
REQ-030 After reset, fetch request (CS, offset 0000_FFF0) -> next cycle rsp_valid=1, rsp_id=0, rsp_linear=000F_FFF0, rsp_fault=0.
REQ-031 DS=FFFF, data request offset 0000_FFFF, a20_enable=1 -> rsp_linear=0010_FFEF; repeated with a20_enable=0 -> 0000_FFEF.
REQ-032 Both requesters valid continuously with rsp_ready=1 -> grants alternate fetch, data, fetch, data with one response per cycle.
REQ-033 Offset 0001_0000 -> rsp_fault=1 and rsp_linear=base+0001_0000; req_seg=7 -> rsp_fault=1 and rsp_linear=0.
REQ-034 Same cycle: seg_wr_en, sel=DS, data=1234 and data request (DS, offset 0010) -> rsp_linear=0001_2350.
REQ-035 rsp_ready held low for 3 cycles -> outputs stable, req_ready=0; reset_n pulsed while FULL -> rsp_valid=0 immediately and CS reads back F000.
